// File: rtl/clause_check_scheduler.sv
// Sequencer for the unsatisfied-clause selection datapath: loads the formula one clause
// per handshake, then runs check rounds (enable, wait for all checkers, decide) on request.
module clause_check_scheduler #(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
    parameter int CHECK_TIMEOUT_CYCLES               = 16,
    parameter int MAXIMUM_BIT_WIDTH_OF_ITERATIONS    = 8
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset,
    input  logic                                          in_setup_start,
    input  logic                                          in_coeff_valid,
    output logic                                          out_coeff_ready,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_load_index,
    output logic                                          out_load_strobe,
    output logic                                          out_setup_done,
    input  logic                                          in_check_start,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_checker_ready,
    input  logic                                          in_formula_satisfied,
    input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_unsat_index,
    output logic [(2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_checker_enable,
    output logic                                          out_read_enable,
    output logic                                          out_result_valid,
    output logic                                          out_result_satisfied,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_unsat_index,
    output logic                                          out_busy,
    output logic                                          out_timeout,
    output logic [MAXIMUM_BIT_WIDTH_OF_ITERATIONS-1:0]    out_iteration_count
);

    localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int NC = 2 ** CI;
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_ITERATIONS;
    localparam int TW = $clog2(CHECK_TIMEOUT_CYCLES + 1);

    localparam logic [CI-1:0] LAST_INDEX    = {CI{1'b1}};
    localparam logic [CI-1:0] INDEX_ONE     = {{(CI-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] ITER_ONE      = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TIMER_ONE     = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(CHECK_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DECIDE = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t          state_r, state_s;
    logic [CI-1:0]   load_idx_r, load_idx_s;
    logic [TW-1:0]   timer_r, timer_s, timer_inc_s;
    logic [NC-1:0]   enable_r, enable_s;
    logic            read_en_r, read_en_s;
    logic            result_valid_r, result_valid_s;
    logic            result_sat_r, result_sat_s;
    logic [CI-1:0]   unsat_idx_r, unsat_idx_s;
    logic            busy_r, busy_s;
    logic            timeout_r, timeout_s;
    logic            setup_done_r, setup_done_s;
    logic [IW-1:0]   iter_r, iter_s;
    logic            accept_s;
    logic            all_ready_s;

    assign accept_s    = in_coeff_valid & (state_r == ST_LOAD);
    assign all_ready_s = &in_checker_ready;
    assign timer_inc_s = timer_r + TIMER_ONE;

    // State and registered-output flops
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_r        <= ST_IDLE;
            load_idx_r     <= '0;
            timer_r        <= '0;
            enable_r       <= '0;
            read_en_r      <= 1'b0;
            result_valid_r <= 1'b0;
            result_sat_r   <= 1'b0;
            unsat_idx_r    <= '0;
            busy_r         <= 1'b0;
            timeout_r      <= 1'b0;
            setup_done_r   <= 1'b0;
            iter_r         <= '0;
        end else begin
            state_r        <= state_s;
            load_idx_r     <= load_idx_s;
            timer_r        <= timer_s;
            enable_r       <= enable_s;
            read_en_r      <= read_en_s;
            result_valid_r <= result_valid_s;
            result_sat_r   <= result_sat_s;
            unsat_idx_r    <= unsat_idx_s;
            busy_r         <= busy_s;
            timeout_r      <= timeout_s;
            setup_done_r   <= setup_done_s;
            iter_r         <= iter_s;
        end
    end

    // Next-state decode; setup_start takes priority over check_start in READY
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = in_setup_start ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_s = (accept_s && (load_idx_r == LAST_INDEX)) ? ST_READY : ST_LOAD;
            ST_READY: begin
                if (in_setup_start) begin
                    state_s = ST_LOAD;
                end else if (in_check_start) begin
                    state_s = ST_ENABLE;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_ENABLE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (all_ready_s) begin
                    state_s = ST_DECIDE;
                end else if (timer_inc_s == TIMEOUT_LIMIT) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DECIDE: state_s = ST_READY;
            ST_FAULT:  state_s = in_setup_start ? ST_LOAD : ST_FAULT;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the transition being taken
    always_comb begin
        load_idx_s     = load_idx_r;
        timer_s        = timer_r;
        read_en_s      = 1'b0;
        result_valid_s = 1'b0;
        result_sat_s   = result_sat_r;
        unsat_idx_s    = unsat_idx_r;
        timeout_s      = timeout_r;
        setup_done_s   = setup_done_r;
        iter_s         = iter_r;
        enable_s       = (state_s == ST_ENABLE) ? {NC{1'b1}} : {NC{1'b0}};
        busy_s         = (state_s == ST_LOAD) || (state_s == ST_ENABLE) ||
                         (state_s == ST_WAIT) || (state_s == ST_DECIDE);
        case (state_r)
            ST_IDLE, ST_READY, ST_FAULT: begin
                if (in_setup_start) begin
                    load_idx_s   = '0;
                    setup_done_s = 1'b0;
                    iter_s       = '0;
                    timeout_s    = 1'b0;
                end else begin
                    load_idx_s   = load_idx_r;
                end
            end
            ST_LOAD: begin
                // The index holds at the last clause once the formula is complete
                if (accept_s && (load_idx_r == LAST_INDEX)) begin
                    setup_done_s = 1'b1;
                end else if (accept_s) begin
                    load_idx_s   = load_idx_r + INDEX_ONE;
                end else begin
                    load_idx_s   = load_idx_r;
                end
            end
            ST_ENABLE: timer_s = '0;
            ST_WAIT: begin
                if (all_ready_s) begin
                    result_valid_s = 1'b1;
                    result_sat_s   = in_formula_satisfied;
                    read_en_s      = ~in_formula_satisfied;
                    unsat_idx_s    = in_formula_satisfied ? unsat_idx_r : in_unsat_index;
                    iter_s         = (&iter_r) ? iter_r : (iter_r + ITER_ONE);
                end else begin
                    timer_s        = timer_inc_s;
                    timeout_s      = timeout_r | (timer_inc_s == TIMEOUT_LIMIT);
                end
            end
            default: timer_s = timer_r;
        endcase
    end

    assign out_coeff_ready      = (state_r == ST_LOAD);
    assign out_load_strobe      = accept_s;
    assign out_load_index       = load_idx_r;
    assign out_setup_done       = setup_done_r;
    assign out_checker_enable   = enable_r;
    assign out_read_enable      = read_en_r;
    assign out_result_valid     = result_valid_r;
    assign out_result_satisfied = result_sat_r;
    assign out_unsat_index      = unsat_idx_r;
    assign out_busy             = busy_r;
    assign out_timeout          = timeout_r;
    assign out_iteration_count  = iter_r;

endmodule

// File: tb/tb_clause_check_scheduler.sv
// Directed bench for clause_check_scheduler: a cycle-level expectation model driven by
// the stimulus tasks, compared against every DUT output on each falling clock edge.
module tb_clause_check_scheduler;

    logic       clk;
    logic       in_reset;
    logic       in_setup_start;
    logic       in_coeff_valid;
    logic       out_coeff_ready;
    logic [1:0] out_load_index;
    logic       out_load_strobe;
    logic       out_setup_done;
    logic       in_check_start;
    logic [3:0] in_checker_ready;
    logic       in_formula_satisfied;
    logic [1:0] in_unsat_index;
    logic [3:0] out_checker_enable;
    logic       out_read_enable;
    logic       out_result_valid;
    logic       out_result_satisfied;
    logic [1:0] out_unsat_index;
    logic       out_busy;
    logic       out_timeout;
    logic [7:0] out_iteration_count;

    clause_check_scheduler #(
        .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2),
        .CHECK_TIMEOUT_CYCLES(16),
        .MAXIMUM_BIT_WIDTH_OF_ITERATIONS(8)
    ) dut (
        .in_clk(clk),
        .in_reset(in_reset),
        .in_setup_start(in_setup_start),
        .in_coeff_valid(in_coeff_valid),
        .out_coeff_ready(out_coeff_ready),
        .out_load_index(out_load_index),
        .out_load_strobe(out_load_strobe),
        .out_setup_done(out_setup_done),
        .in_check_start(in_check_start),
        .in_checker_ready(in_checker_ready),
        .in_formula_satisfied(in_formula_satisfied),
        .in_unsat_index(in_unsat_index),
        .out_checker_enable(out_checker_enable),
        .out_read_enable(out_read_enable),
        .out_result_valid(out_result_valid),
        .out_result_satisfied(out_result_satisfied),
        .out_unsat_index(out_unsat_index),
        .out_busy(out_busy),
        .out_timeout(out_timeout),
        .out_iteration_count(out_iteration_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    logic chk_on = 1'b0;

    // Expected output levels for the current cycle
    logic       m_busy, m_cready, m_sdone, m_re, m_rv, m_rsat, m_to;
    logic [1:0] m_lidx, m_uidx;
    logic [3:0] m_en;
    logic [7:0] m_iter;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_zero();
        m_busy = 1'b0; m_cready = 1'b0; m_sdone = 1'b0; m_re = 1'b0; m_rv = 1'b0;
        m_rsat = 1'b0; m_to = 1'b0; m_lidx = 2'd0; m_uidx = 2'd0; m_en = 4'd0; m_iter = 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_en = 4'd0;
        m_rv = 1'b0;
        m_re = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", out_busy, m_busy);
            chk("coeff_ready", out_coeff_ready, m_cready);
            chk("load_strobe", out_load_strobe, m_cready & in_coeff_valid);
            if (m_cready) chk("load_index", out_load_index, m_lidx);
            chk("setup_done", out_setup_done, m_sdone);
            chk("checker_enable", out_checker_enable, m_en);
            chk("read_enable", out_read_enable, m_re);
            chk("result_valid", out_result_valid, m_rv);
            chk("result_satisfied", out_result_satisfied, m_rsat);
            chk("unsat_index", out_unsat_index, m_uidx);
            chk("timeout", out_timeout, m_to);
            chk("iteration_count", out_iteration_count, m_iter);
        end
    end

    // Load the formula: valid follows pat (bit 0 first) for n cycles
    task automatic do_load(input logic [7:0] pat, input int n, input logic with_check);
        int cnt;
        in_setup_start = 1'b1;
        in_check_start = with_check;
        tick();
        in_setup_start = 1'b0;
        in_check_start = 1'b0;
        m_busy = 1'b1; m_cready = 1'b1; m_sdone = 1'b0; m_iter = 8'd0; m_to = 1'b0; m_lidx = 2'd0;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            in_coeff_valid = pat[i];
            tick();
            if (pat[i] && cnt < 4) begin
                cnt++;
                if (cnt == 4) begin
                    m_cready = 1'b0; m_busy = 1'b0; m_sdone = 1'b1;
                end else begin
                    m_lidx = 2'(cnt);
                end
            end
        end
        in_coeff_valid = 1'b0;
        tick();
    endtask

    // One check round; all-ready arrives after rdelay non-ready WAIT cycles
    task automatic check_round(input int rdelay, input logic sat, input logic [1:0] idx,
                               input logic [3:0] stale);
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        in_checker_ready = stale;
        m_en = 4'hf; m_busy = 1'b1;
        tick();
        for (int k = 0; k < rdelay; k++) begin
            in_checker_ready = 4'b0111;
            tick();
        end
        in_checker_ready = 4'hf;
        in_formula_satisfied = sat;
        in_unsat_index = idx;
        tick();
        m_rv = 1'b1; m_re = ~sat; m_rsat = sat;
        if (!sat) m_uidx = idx;
        if (m_iter != 8'hff) m_iter = m_iter + 8'd1;
        in_checker_ready = 4'd0;
        in_formula_satisfied = 1'b0;
        in_unsat_index = 2'd0;
        tick();
        m_busy = 1'b0;
    endtask

    initial begin
        in_reset = 1'b1; in_setup_start = 1'b0; in_coeff_valid = 1'b0; in_check_start = 1'b0;
        in_checker_ready = 4'd0; in_formula_satisfied = 1'b0; in_unsat_index = 2'd0;
        model_zero();
        #1 in_reset = 1'b0;
        chk_on = 1'b1;
        tick(); tick();
        chk("reset outputs", {out_busy, out_setup_done, out_timeout, out_iteration_count, out_load_index}, 32'd0);
        in_reset = 1'b1;
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        tick();

        // Load with gaps in valid
        do_load(8'b0010_1101, 6, 1'b0);
        chk("setup_done after load", out_setup_done, 32'd1);
        chk("load index held", out_load_index, 32'd3);

        check_round(2, 1'b1, 2'd0, 4'd0);
        chk("iter after sat round", out_iteration_count, 32'd1);
        chk("sat held", out_result_satisfied, 32'd1);

        check_round(2, 1'b0, 2'd2, 4'hf);
        chk("unsat index held", out_unsat_index, 32'd2);
        chk("iter after unsat round", out_iteration_count, 32'd2);

        check_round(0, 1'b0, 2'd1, 4'd0);
        check_round(1, 1'b1, 2'd3, 4'd0);
        chk("index kept on sat", out_unsat_index, 32'd1);
        chk("iter after 4 rounds", out_iteration_count, 32'd4);

        // Timeout: ready stuck at 0111
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        m_en = 4'hf; m_busy = 1'b1;
        tick();
        in_checker_ready = 4'b0111;
        repeat (16) tick();
        m_to = 1'b1; m_busy = 1'b0;
        chk("timeout raised", out_timeout, 32'd1);
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        in_checker_ready = 4'd0;
        repeat (3) tick();
        chk("timeout sticky", out_timeout, 32'd1);
        do_load(8'b0000_1111, 4, 1'b0);
        chk("timeout cleared", out_timeout, 32'd0);
        chk("iter cleared", out_iteration_count, 32'd0);

        // setup_start and check_start together in READY
        do_load(8'b0000_1111, 4, 1'b1);
        check_round(0, 1'b0, 2'd3, 4'd0);

        // Asynchronous reset in the middle of WAIT
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        m_en = 4'hf; m_busy = 1'b1;
        tick();
        in_checker_ready = 4'b0011;
        tick();
        #2 in_reset = 1'b0;
        model_zero();
        #1;
        chk("async reset outputs", {out_busy, out_checker_enable, out_read_enable, out_result_valid,
            out_result_satisfied, out_unsat_index, out_timeout, out_iteration_count,
            out_setup_done, out_load_index, out_coeff_ready, out_load_strobe}, 32'd0);
        tick();
        in_reset = 1'b1;
        in_checker_ready = 4'd0;
        in_check_start = 1'b1;
        tick();
        in_check_start = 1'b0;
        repeat (3) tick();
        do_load(8'b0000_1111, 4, 1'b0);
        check_round(1, 1'b1, 2'd0, 4'd0);
        chk("iter after reset and round", out_iteration_count, 32'd1);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
